// File: rtl/bp_be_fp_unpack_pipe_if.sv
// Handshake/data bundle for bp_be_fp_unpack_pipe.
//   Input side : v_i, ready_o, reg_i {sp_not_dp, rec[64:0]}, tag_i
//   Output side: v_o, yumi_i, data_o (IEEE raw, SP NaN-boxed), fclass_o, tag_o
// master = producer/consumer environment, slave = the unpack unit.
interface bp_be_fp_unpack_pipe_if #(parameter int tag_width_p = 5);
  logic                   v_i;
  logic                   ready_o;
  logic [65:0]            reg_i;
  logic [tag_width_p-1:0] tag_i;
  logic                   v_o;
  logic                   yumi_i;
  logic [63:0]            data_o;
  logic [9:0]             fclass_o;
  logic [tag_width_p-1:0] tag_o;

  modport master (
    output v_i, reg_i, tag_i, yumi_i,
    input  ready_o, v_o, data_o, fclass_o, tag_o
  );

  modport slave (
    input  v_i, reg_i, tag_i, yumi_i,
    output ready_o, v_o, data_o, fclass_o, tag_o
  );
endinterface

// File: rtl/bp_be_fp_unpack_pipe.sv
// Two-stage unit converting a recoded FP register value into its IEEE-754
// raw 64-bit image plus the RISC-V fclass mask.
//   clk_i   : clock
//   reset_i : synchronous, active-high reset; flushes both stages
//   io      : slave side of bp_be_fp_unpack_pipe_if (valid/ready in,
//             valid/yumi out, 66-bit recoded in, 64-bit raw + fclass out)
// S1 decodes class/exponent/shift; S2 denormalizes, assembles and holds the
// result. Only ready_o depends combinationally on yumi_i.
module bp_be_fp_unpack_pipe #(
  parameter int tag_width_p = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bp_be_fp_unpack_pipe_if.slave  io
);

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_SNAN, CLS_QNAN
  } cls_e;

  // ---------------- S1 decode ----------------
  logic        w_sp, w_sign, w_fract_msb, w_is_norm;
  logic [11:0] w_exp_dp;
  logic [8:0]  w_exp_sp;
  logic [2:0]  w_top3;
  logic [51:0] w_fract;
  logic [10:0] w_exp_norm;
  logic [11:0] w_sh_dp;
  logic [8:0]  w_sh_sp;
  logic [5:0]  w_sh;
  cls_e        w_cls;

  assign w_sp        = io.reg_i[65];
  assign w_exp_dp    = io.reg_i[63:52];
  assign w_exp_sp    = io.reg_i[31:23];
  assign w_sign      = w_sp ? io.reg_i[32] : io.reg_i[64];
  assign w_top3      = w_sp ? w_exp_sp[8:6] : w_exp_dp[11:9];
  assign w_fract     = w_sp ? {29'b0, io.reg_i[22:0]} : io.reg_i[51:0];
  assign w_fract_msb = w_sp ? io.reg_i[22] : io.reg_i[51];
  assign w_is_norm   = w_sp ? (w_exp_sp >= 9'h082) : (w_exp_dp >= 12'h402);

  // Rebias modulo the IEEE field width; upper bits drop out naturally.
  assign w_exp_norm  = w_sp ? {3'b0, w_exp_sp[7:0] - 8'h81}
                            : (w_exp_dp[10:0] - 11'h401);

  // Denormalizing shift; exponents below the legal subnormal range clamp
  // to 63, which shifts the whole mantissa out.
  assign w_sh_dp = 12'h402 - w_exp_dp;
  assign w_sh_sp = 9'h082 - w_exp_sp;
  always_comb begin
    w_sh = 6'd63;
    if (w_sp) begin
      if (w_sh_sp < 9'd64) w_sh = w_sh_sp[5:0];
    end else begin
      if (w_sh_dp < 12'd64) w_sh = w_sh_dp[5:0];
    end
  end

  always_comb begin
    w_cls = CLS_NORM;
    case (w_top3)
      3'b000:  w_cls = CLS_ZERO;
      3'b110:  w_cls = CLS_INF;
      3'b111:  w_cls = w_fract_msb ? CLS_QNAN : CLS_SNAN;
      default: w_cls = w_is_norm ? CLS_NORM : CLS_SUB;
    endcase
  end

  // ---------------- handshake ----------------
  logic r_s1_v, r_s2_v;
  logic w_s2_ld, w_s1_adv, w_acc;

  assign w_s2_ld    = ~r_s2_v | io.yumi_i;
  assign w_s1_adv   = r_s1_v & w_s2_ld;
  assign io.ready_o = ~reset_i & (~r_s1_v | w_s1_adv);
  assign w_acc      = io.v_i & io.ready_o;

  // ---------------- S1 registers ----------------
  logic                   r_s1_sign, r_s1_sp;
  cls_e                   r_s1_cls;
  logic [51:0]            r_s1_fract;
  logic [5:0]             r_s1_sh;
  logic [10:0]            r_s1_exp;
  logic [tag_width_p-1:0] r_s1_tag;

  // ---------------- S2 assemble ----------------
  logic [52:0] w_mant;
  logic [51:0] w_sub_fract;
  logic [10:0] w_exp_o;
  logic [51:0] w_fr_o;
  logic [9:0]  w_fc;
  logic [63:0] w_data;

  // Hidden one sits just above the fraction field for either precision.
  assign w_mant      = r_s1_sp ? {29'b0, 1'b1, r_s1_fract[22:0]} : {1'b1, r_s1_fract};
  assign w_sub_fract = 52'(w_mant >> r_s1_sh);

  always_comb begin
    w_exp_o = '0;
    w_fr_o  = '0;
    w_fc    = '0;
    case (r_s1_cls)
      CLS_ZERO: w_fc[r_s1_sign ? 3 : 4] = 1'b1;
      CLS_SUB: begin
        w_fr_o = w_sub_fract;
        w_fc[r_s1_sign ? 2 : 5] = 1'b1;
      end
      CLS_NORM: begin
        w_exp_o = r_s1_exp;
        w_fr_o  = r_s1_fract;
        w_fc[r_s1_sign ? 1 : 6] = 1'b1;
      end
      CLS_INF: begin
        w_exp_o = '1;
        w_fc[r_s1_sign ? 0 : 7] = 1'b1;
      end
      CLS_SNAN: begin
        w_exp_o = '1;
        w_fr_o  = r_s1_fract;
        w_fc[8] = 1'b1;
      end
      CLS_QNAN: begin
        w_exp_o = '1;
        w_fr_o  = r_s1_fract;
        w_fc[9] = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_data = r_s1_sp ? {32'hFFFF_FFFF, r_s1_sign, w_exp_o[7:0], w_fr_o[22:0]}
                          : {r_s1_sign, w_exp_o, w_fr_o};

  // ---------------- S2 registers ----------------
  logic [63:0]            r_s2_data;
  logic [9:0]             r_s2_fc;
  logic [tag_width_p-1:0] r_s2_tag;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_fc   <= '0;
      r_s2_tag  <= '0;
    end else begin
      if (io.ready_o) r_s1_v <= io.v_i;
      if (w_acc) begin
        r_s1_sign  <= w_sign;
        r_s1_sp    <= w_sp;
        r_s1_cls   <= w_cls;
        r_s1_fract <= w_fract;
        r_s1_sh    <= w_sh;
        r_s1_exp   <= w_exp_norm;
        r_s1_tag   <= io.tag_i;
      end
      if (w_s2_ld) r_s2_v <= r_s1_v;
      if (w_s1_adv) begin
        r_s2_data <= w_data;
        r_s2_fc   <= w_fc;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign io.v_o      = r_s2_v;
  assign io.data_o   = r_s2_data;
  assign io.fclass_o = r_s2_fc;
  assign io.tag_o    = r_s2_tag;

endmodule

// File: doc/bp_be_fp_unpack_pipe.md
# bp_be_fp_unpack_pipe

Two-stage pipelined backend unit that takes a floating-point register value in the packed recoded-register form (`sp_not_dp` plus 65-bit HardFloat recoded value) and produces the IEEE-754 raw 64-bit image plus the RISC-V 10-bit `fclass` mask. It sits directly downstream of the FP register file read port. It feeds FP store data (`fsd`/`fsw`), `fmv.x.*` and `fclass.*` results toward the integer writeback and store paths. Single-precision values come out NaN-boxed.

## Interface
- `tag_width_p`, default 5: width of the pass-through tag (destination register or ROB id).
- `clk_i`  in  1: clock. One clock domain.
- `reset_i`  in  1: reset. Synchronous, active-high.
- `v_i`  in  1: input valid.
- `ready_o`  out  1: unit can accept this cycle. A transfer occurs when `v_i & ready_o`.
- `reg_i`  in  66: `{sp_not_dp, rec[64:0]}`.
  - DP: sign `rec[64]`, exp `rec[63:52]` (12 b), fract `rec[51:0]`.
  - SP, when `sp_not_dp=1`: sign `rec[32]`, exp `rec[31:23]` (9 b), fract `rec[22:0]`. `rec[64:33]` is ignored.
- `tag_i`  in  `tag_width_p`: carried alongside the data.
- `v_o`  out  1: output valid.
- `yumi_i`  in  1: consumer takes output. Legal only when `v_o=1`.
- `data_o`  out  64: IEEE raw image.
- `fclass_o`  out  10: one-hot class mask.
- `tag_o`  out  `tag_width_p`: tag of the output entry.

## Operation
- Class from the top 3 bits of the recoded exp `E`:
  - `000`: zero.
  - `110`: infinity.
  - `111`: NaN. Quiet if fract MSB=1, otherwise signalling.
  - Any other value: finite nonzero.
- DP finite nonzero:
  - `E >= 0x402`: normal. IEEE exp = `(E - 0x401)[10:0]`, fract passed through.
  - `E < 0x402`: subnormal. `sh = 0x402 - E`, range 1..52. IEEE exp = 0, fract = `({1'b1,fract} >> sh)[51:0]`.
- SP finite nonzero:
  - Same rules with offset `0x81` and min-normal threshold `0x82`. `sh` range 1..23. Fields are 8-bit exp and 23-bit fract.
- Zero: exp 0, fract 0. Inf: exp all-ones, fract 0. NaN: exp all-ones, fract passed unchanged. Sign is always passed through.
- SP output: `{32'hFFFF_FFFF, sign, exp[7:0], fract[22:0]}`.
- `fclass_o` bit assignment:
  - bit 0: −inf. bit 1: −normal. bit 2: −subnormal. bit 3: −0.
  - bit 4: +0. bit 5: +subnormal. bit 6: +normal. bit 7: +inf.
  - bit 8: sNaN. bit 9: qNaN.
  - Exactly one bit is set.
- Stage 1 (S1) registers: sign, class, precision, selected fract, the clamped shift amount, the normal-exp result, and the tag.
- Stage 2 (S2) registers: the shifted fract, the assembled `data_o`, `fclass_o` and `tag_o`.
- Each stage has a valid bit. Out-of-range `E` values that cannot occur in legal recoded data map to the subnormal path with `sh` clamped to 63. The result then has fract 0.

## Timing
- Latency: a transfer in cycle N gives `v_o=1` in cycle N+2, with no stall.
- Throughput: 1 per cycle.
- Advance rules:
  - S2 loads when `~s2_v | yumi_i`.
  - S1 advances into S2 under the same condition.
  - S1 loads a new input when `~s1_v | s1_advance`.
  - `ready_o = ~s1_v | s1_advance`. It is combinational from `yumi_i`; this is the one allowed comb path.
- Stall: while `v_o & ~yumi_i`, S2 outputs are held stable bit-for-bit. S1 holds once full. At most 2 entries are in flight. Order is strictly FIFO.
- Simultaneous events: input accept, S1→S2 move and output consume may all occur in the same cycle with no bubble.
- Bubble: with S1 empty and S2 consumed, `v_o` goes low the next cycle.
- Reset:
  - While `reset_i=1`: `ready_o=0`.
  - The cycle after reset: `v_o=0`, `data_o=0`, `fclass_o=0`, `tag_o=0`; `ready_o=1` from the first cycle after reset deassertion.
  - Reset during operation discards all in-flight entries. No output appears for them.

## Test plan
- DP 1.0, `rec=65'h0_80000000_00000000`, tag 3 → two cycles later `data_o=64'h3FF0_0000_0000_0000`, `fclass_o=10'h040`, `tag_o=3`.
- DP canonical NaN `65'h0_e0080000_00000000` → `64'h7FF8_0000_0000_0000`, `fclass_o=10'h200`. With fract MSB cleared and `fract=1` → `64'h7FF0_0000_0000_0001`, `fclass_o=10'h100`.
- SP 1.0, `sp_not_dp=1`, `rec[32:0]=33'h0_8000_0000` → `64'hFFFF_FFFF_3F80_0000`, `fclass_o=10'h040`. SP −0 (`rec[32:0]=33'h1_0000_0000`) → `64'hFFFF_FFFF_8000_0000`, `fclass_o=10'h008`.
- DP smallest subnormal, `E=0x3CE`, fract 0 → `64'h0000_0000_0000_0001`, `fclass_o=10'h020`. DP −inf (`E=0xC00`, sign 1) → `64'hFFF0_0000_0000_0000`, `fclass_o=10'h001`.
- Backpressure: 4 back-to-back inputs with `yumi_i=0` for 3 cycles after the first `v_o` → `ready_o` drops once S1 and S2 are full. No entry is lost or duplicated, all 4 outputs come out in order, and held outputs stay stable.
- Assert `reset_i` for 1 cycle with 2 entries in flight → `v_o=0` the next cycle and the flushed entries never appear. A new input afterward emerges 2 cycles after its accept.
